eight_point_ifft_seq: RTL and testbench



---
 rtl/ifft_pkg.sv | 56 +++++
 rtl/ifft_butterfly.sv | 40 ++++
 rtl/eight_point_ifft_seq.sv | 158 +++++++++++++++
 tb/tb_eight_point_ifft_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifft_pkg.sv
// Shared types, constants and Q8.8 helpers for the sequential 8-point IFFT.
// Sample words are sign-magnitude at the ports and two's complement internally.
package ifft_pkg;

   localparam int W_P  = 16;
   localparam int IW_P = 18;

   localparam logic [W_P-1:0] ONE = 16'h0100;

   typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_e;

   typedef logic signed [IW_P-1:0] iw_t;

   typedef struct packed {
      iw_t re;
      iw_t im;
   } cplx_t;

   localparam iw_t SAT_MAX = iw_t'(32767);
   localparam iw_t SAT_MIN = iw_t'(-32768);

   function automatic logic [2:0] bitrev3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   // Shift-add approximation of cos(pi/4): 1/2+1/8+1/16+1/64+1/256 = 0.70703
   function automatic iw_t c_mul(input iw_t v);
      return (v >>> 1) + (v >>> 3) + (v >>> 4) + (v >>> 6) + (v >>> 8);
   endfunction

   function automatic iw_t sm_to_tc(input logic [W_P-1:0] sm);
      iw_t mag;
      mag = iw_t'({{(IW_P-W_P+1){1'b0}}, sm[W_P-2:0]});
      return sm[W_P-1] ? -mag : mag;
   endfunction

   function automatic iw_t sat_w(input iw_t v);
      iw_t r;
      r = v;
      if (v > SAT_MAX) r = SAT_MAX;
      if (v < SAT_MIN) r = SAT_MIN;
      return r;
   endfunction

   // -32768 has no sign-magnitude code, so it clamps to -32767 (0xFFFF)
   function automatic logic [W_P-1:0] tc_to_sm(input iw_t v);
      iw_t             mag;
      logic [W_P-1:0]  r;
      mag = v[IW_P-1] ? -v : v;
      if (mag > SAT_MAX || mag < 0) mag = SAT_MAX;
      if (mag == 0) r = '0;
      else          r = {v[IW_P-1], mag[W_P-2:0]};
      return r;
   endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with conjugate twiddles and a built-in /2 scale.
// A' = (A + B*W^k) >>> 1, B' = (A - B*W^k) >>> 1, k = 0..3.
module ifft_butterfly
   import ifft_pkg::*;
(
   input  cplx_t      a_i,
   input  cplx_t      b_i,
   input  logic [1:0] tw_i,
   output cplx_t      a_o,
   output cplx_t      b_o
);

   iw_t b_re, b_im, diff, sum;
   iw_t t_re, t_im;
   iw_t a_re_s, a_im_s, b_re_s, b_im_s;

   always_comb begin
      b_re = b_i.re;
      b_im = b_i.im;
      diff = b_re - b_im;
      sum  = b_re + b_im;
      t_re = b_re;
      t_im = b_im;
      case (tw_i)
         2'd0: begin t_re = b_re;         t_im = b_im;         end
         2'd1: begin t_re = c_mul(diff);  t_im = c_mul(sum);   end
         2'd2: begin t_re = -b_im;        t_im = b_re;         end
         default: begin t_re = -c_mul(sum); t_im = c_mul(diff); end
      endcase
      a_re_s = a_i.re + t_re;
      a_im_s = a_i.im + t_im;
      b_re_s = a_i.re - t_re;
      b_im_s = a_i.im - t_im;
      a_o.re = a_re_s >>> 1;
      a_o.im = a_im_s >>> 1;
      b_o.re = b_re_s >>> 1;
      b_o.im = b_im_s >>> 1;
   end

endmodule

// File: rtl/eight_point_ifft_seq.sv
// Sequential 8-point IFFT: serial load, 12-cycle in-place butterfly pass, serial unload.
// Output is valid/ready with data held while out_ready is low; latency 14 cycles from last input.
module eight_point_ifft_seq
   import ifft_pkg::*;
#(
   parameter int W  = W_P,
   parameter int IW = IW_P
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_real,
   input  logic [W-1:0] in_imag,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_real,
   output logic [W-1:0] out_imag,
   output logic [2:0]   out_index,
   output logic         out_last,
   output logic         busy
);

   state_e state_q, state_d;

   logic [2:0]   ld_cnt_q, ld_cnt_d;
   logic [1:0]   stg_q, stg_d;
   logic [1:0]   bf_q, bf_d;
   logic [2:0]   out_idx_q, out_idx_d;
   logic         out_vld_q, out_vld_d;
   logic [W-1:0] out_re_q, out_re_d;
   logic [W-1:0] out_im_q, out_im_d;

   logic signed [IW-1:0] st_re_q [8];
   logic signed [IW-1:0] st_im_q [8];

   logic       in_fire, out_fire, ld_we, bf_we;
   logic [2:0] ia, ib, rd_idx;
   logic [1:0] tw;
   cplx_t      bf_a, bf_b, bf_a_o, bf_b_o;

   assign in_ready  = (state_q == LOAD);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_vld_q & out_ready;
   assign rd_idx    = out_vld_q ? out_idx_q + 3'd1 : 3'd0;

   assign out_valid = out_vld_q;
   assign out_real  = out_re_q;
   assign out_imag  = out_im_q;
   assign out_index = out_idx_q;
   assign out_last  = out_vld_q & (out_idx_q == 3'd7);
   assign busy      = (state_q != LOAD);

   // Operand spacing 1/2/4 per stage; twiddle step halves each stage
   always_comb begin
      ia = {bf_q, 1'b0};
      ib = {bf_q, 1'b1};
      tw = 2'd0;
      case (stg_q)
         2'd0: begin ia = {bf_q, 1'b0};          ib = {bf_q, 1'b1};          tw = 2'd0;            end
         2'd1: begin ia = {bf_q[1], 1'b0, bf_q[0]}; ib = {bf_q[1], 1'b1, bf_q[0]}; tw = {bf_q[0], 1'b0}; end
         default: begin ia = {1'b0, bf_q};       ib = {1'b1, bf_q};          tw = bf_q;            end
      endcase
      bf_a.re = st_re_q[ia];
      bf_a.im = st_im_q[ia];
      bf_b.re = st_re_q[ib];
      bf_b.im = st_im_q[ib];
   end

   ifft_butterfly u_bfly (
      .a_i  (bf_a),
      .b_i  (bf_b),
      .tw_i (tw),
      .a_o  (bf_a_o),
      .b_o  (bf_b_o)
   );

   always_comb begin
      state_d   = state_q;
      ld_cnt_d  = ld_cnt_q;
      stg_d     = stg_q;
      bf_d      = bf_q;
      out_idx_d = out_idx_q;
      out_vld_d = out_vld_q;
      out_re_d  = out_re_q;
      out_im_d  = out_im_q;
      ld_we     = 1'b0;
      bf_we     = 1'b0;
      case (state_q)
         LOAD: begin
            stg_d = 2'd0;
            bf_d  = 2'd0;
            if (in_fire) begin
               ld_we    = 1'b1;
               ld_cnt_d = ld_cnt_q + 3'd1;
               if (ld_cnt_q == 3'd7) state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            bf_we = 1'b1;
            bf_d  = bf_q + 2'd1;
            if (bf_q == 2'd3) begin
               stg_d = stg_q + 2'd1;
               if (stg_q == 2'd2) state_d = UNLOAD;
            end
         end
         UNLOAD: begin
            // Refill the output register on entry and after each accepted sample but the last
            if (!out_vld_q || (out_fire && out_idx_q != 3'd7)) begin
               out_vld_d = 1'b1;
               out_idx_d = rd_idx;
               out_re_d  = tc_to_sm(st_re_q[rd_idx]);
               out_im_d  = tc_to_sm(st_im_q[rd_idx]);
            end else if (out_fire) begin
               out_vld_d = 1'b0;
               out_idx_d = 3'd0;
               state_d   = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= LOAD;
         ld_cnt_q  <= 3'd0;
         stg_q     <= 2'd0;
         bf_q      <= 2'd0;
         out_idx_q <= 3'd0;
         out_vld_q <= 1'b0;
         out_re_q  <= '0;
         out_im_q  <= '0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         stg_q     <= stg_d;
         bf_q      <= bf_d;
         out_idx_q <= out_idx_d;
         out_vld_q <= out_vld_d;
         out_re_q  <= out_re_d;
         out_im_q  <= out_im_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (ld_we) begin
         st_re_q[bitrev3(ld_cnt_q)] <= sm_to_tc(in_real);
         st_im_q[bitrev3(ld_cnt_q)] <= sm_to_tc(in_imag);
      end else if (bf_we) begin
         st_re_q[ia] <= sat_w(bf_a_o.re);
         st_im_q[ia] <= sat_w(bf_a_o.im);
         st_re_q[ib] <= sat_w(bf_b_o.re);
         st_im_q[ib] <= sat_w(bf_b_o.im);
      end
   end

endmodule

// File: tb/tb_eight_point_ifft_seq.sv
// Directed bench for eight_point_ifft_seq: impulse, constant, single-bin, backpressure,
// latency, ignored in_valid outside LOAD, mid-COMPUTE reset and -0 input.
module tb_eight_point_ifft_seq;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_real = 16'h0000;
   logic [15:0] in_imag = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_real, out_imag;
   logic [2:0]  out_index;
   logic        out_last;
   logic        busy;

   eight_point_ifft_seq #(.W(16), .IW(18)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_real  (out_real),
      .out_imag  (out_imag),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;
   int t_acc = 0;

   logic [15:0] fr_re [8];
   logic [15:0] fr_im [8];
   logic [15:0] exp_re [8];
   logic [15:0] exp_im [8];
   logic        tol [8];
   logic [15:0] got_re [8];
   logic [15:0] got_im [8];
   logic        got_last [8];

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   function automatic int sm2i(input logic [15:0] v);
      return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
   endfunction

   function automatic int near(input logic [15:0] a, input logic [15:0] b);
      int d;
      d = sm2i(a) - sm2i(b);
      return (d <= 2 && d >= -2) ? 1 : 0;
   endfunction

   task automatic clear_frame;
      for (int n = 0; n < 8; n++) begin
         fr_re[n] = 16'h0000; fr_im[n] = 16'h0000;
         exp_re[n] = 16'h0000; exp_im[n] = 16'h0000; tol[n] = 1'b0;
      end
   endtask

   task automatic send_frame;
      int guard;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_real  = fr_re[k];
         in_imag  = fr_im[k];
         guard = 0;
         while (!in_ready && guard < 50) begin
            tick;
            guard++;
         end
         if (guard >= 50) chk("send_timeout", guard, 0);
         if (k == 7) t_acc = cyc;
         tick;
      end
      in_valid = 1'b0;
   endtask

   task automatic recv_frame(input int stall_n, input int stall_len, input bit junk);
      int got, guard, hold;
      logic [15:0] s_re, s_im;
      logic [2:0]  s_idx;
      got = 0; guard = 0; hold = 0;
      s_re = '0; s_im = '0; s_idx = '0;
      for (int n = 0; n < 8; n++) begin
         got_re[n] = 16'hDEAD; got_im[n] = 16'hDEAD; got_last[n] = 1'b0;
      end
      while (got < 8 && guard < 300) begin
         in_valid = junk && (got < 7);
         if (junk) begin in_real = 16'h7FFF; in_imag = 16'h1234; end
         if (hold > 0 && hold < stall_len) begin
            chk("stall_vld", int'(out_valid), 1);
            chk("stall_idx", int'(out_index), int'(s_idx));
            chk("stall_re", int'(out_real), int'(s_re));
            chk("stall_im", int'(out_imag), int'(s_im));
            out_ready = 1'b0;
            hold++;
         end else if (hold == 0 && stall_len > 0 && out_valid && int'(out_index) == stall_n) begin
            s_re = out_real; s_im = out_imag; s_idx = out_index;
            out_ready = 1'b0;
            hold = 1;
         end else begin
            out_ready = 1'b1;
            if (out_valid) begin
               chk("order", int'(out_index), got);
               got_re[out_index]   = out_real;
               got_im[out_index]   = out_imag;
               got_last[out_index] = out_last;
               got++;
            end
         end
         tick;
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("frame_count", got, 8);
      chk("idle_valid", int'(out_valid), 0);
      chk("idle_ready", int'(in_ready), 1);
   endtask

   task automatic check_frame(input string name);
      for (int n = 0; n < 8; n++) begin
         if (tol[n]) begin
            chk($sformatf("%s_re%0d_near", name, n), near(got_re[n], exp_re[n]), 1);
            chk($sformatf("%s_im%0d_near", name, n), near(got_im[n], exp_im[n]), 1);
         end else begin
            chk($sformatf("%s_re%0d", name, n), int'(got_re[n]), int'(exp_re[n]));
            chk($sformatf("%s_im%0d", name, n), int'(got_im[n]), int'(exp_im[n]));
         end
         chk($sformatf("%s_last%0d", name, n), int'(got_last[n]), (n == 7) ? 1 : 0);
      end
   endtask

   initial begin
      int g;
      RST_N = 1'b0;
      repeat (3) tick;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_index", int'(out_index), 0);
      chk("rst_out_real", int'(out_real), 0);
      chk("rst_out_imag", int'(out_imag), 0);
      RST_N = 1'b1;
      tick;

      // Impulse: 8.0 in bin 0 gives 1.0 everywhere
      clear_frame;
      fr_re[0] = 16'h0800;
      for (int n = 0; n < 8; n++) exp_re[n] = 16'h0100;
      send_frame;
      recv_frame(-1, 0, 1'b0);
      check_frame("imp");

      // Constant 1.0 gives 1.0 at n=0; junk in_valid during COMPUTE and UNLOAD
      clear_frame;
      for (int n = 0; n < 8; n++) fr_re[n] = 16'h0100;
      exp_re[0] = 16'h0100;
      send_frame;
      in_valid = 1'b1; in_real = 16'h7FFF; in_imag = 16'h1234;
      chk("compute_in_ready", int'(in_ready), 0);
      chk("compute_busy", int'(busy), 1);
      g = 0;
      while (!out_valid && g < 40) begin
         tick;
         g++;
      end
      chk("latency", cyc - t_acc, 14);
      recv_frame(-1, 0, 1'b1);
      check_frame("const");

      // Single bin k=1 with a 5-cycle stall at n=3
      clear_frame;
      fr_re[1] = 16'h0800;
      exp_re[0] = 16'h0100; exp_im[0] = 16'h0000;
      exp_re[1] = 16'h00B5; exp_im[1] = 16'h00B5; tol[1] = 1'b1;
      exp_re[2] = 16'h0000; exp_im[2] = 16'h0100;
      exp_re[3] = 16'h80B5; exp_im[3] = 16'h00B5; tol[3] = 1'b1;
      exp_re[4] = 16'h8100; exp_im[4] = 16'h0000;
      exp_re[5] = 16'h80B5; exp_im[5] = 16'h80B5; tol[5] = 1'b1;
      exp_re[6] = 16'h0000; exp_im[6] = 16'h8100;
      exp_re[7] = 16'h00B5; exp_im[7] = 16'h80B5; tol[7] = 1'b1;
      send_frame;
      recv_frame(3, 5, 1'b0);
      check_frame("bin1");

      // Reset during COMPUTE aborts the frame
      clear_frame;
      fr_re[0] = 16'h0800;
      send_frame;
      repeat (3) tick;
      chk("mid_busy", int'(busy), 1);
      RST_N = 1'b0;
      tick;
      RST_N = 1'b1;
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_busy", int'(busy), 0);
      tick;

      // Negative zero input gives all-zero output
      clear_frame;
      fr_re[0] = 16'h8000;
      fr_im[0] = 16'h8000;
      send_frame;
      recv_frame(-1, 0, 1'b0);
      check_frame("negz");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
